// File: rtl/restoring_divider.sv
// restoring_divider: sequential N-bit restoring divider, one quotient bit per two cycles.
// Define DIV_SIGNED_EN for two's-complement operands with a quotient truncated toward zero.
module restoring_divider #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);
    localparam int CW = $clog2(N + 1);
    typedef enum logic [2:0] {IDLE, INIT, SHIFT, SUB, FIX, DONE} state_t;
    state_t        state;
    logic [N:0]    r;
    logic [N-1:0]  q, d, a_r, b_r, mag_a, mag_b, q_fix, r_fix;
    logic [CW-1:0] cnt;
`ifdef DIV_SIGNED_EN
    // Magnitudes are N-bit unsigned so that -2^(N-1) stays representable.
    always_comb begin
        mag_a = a_r[N-1] ? -a_r : a_r;
        mag_b = b_r[N-1] ? -b_r : b_r;
        q_fix = (a_r[N-1] ^ b_r[N-1]) ? -q : q;
        r_fix = a_r[N-1] ? -r[N-1:0] : r[N-1:0];
    end
`else
    always_comb begin
        mag_a = a_r;
        mag_b = b_r;
        q_fix = q;
        r_fix = r[N-1:0];
    end
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            a_r         <= '0;
            b_r         <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_r   <= A;
                    b_r   <= B;
                    busy  <= 1'b1;
                    state <= INIT;
                end
                INIT: begin
                    // The first shift of {R,Q} is folded into the load, so the loop starts at SUB.
                    {r, q} <= {{N{1'b0}}, mag_a, 1'b0};
                    d      <= mag_b;
                    cnt    <= '0;
                    if (b_r == '0) begin
                        quotient    <= '1;
                        remainder   <= a_r;
                        div_by_zero <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        state <= SUB;
                    end
                end
                SHIFT: begin
                    {r, q} <= {r[N-1:0], q, 1'b0};
                    state  <= SUB;
                end
                SUB: begin
                    if (r >= {1'b0, d}) begin
                        r    <= r - {1'b0, d};
                        q[0] <= 1'b1;
                    end
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == CW'(N - 1)) ? FIX : SHIFT;
                end
                FIX: begin
                    quotient    <= q_fix;
                    remainder   <= r_fix;
                    div_by_zero <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: scoreboard bench for restoring_divider; done results are popped and compared by a monitor.
module tb_restoring_divider;
    localparam int N   = 4;
    localparam int LAT = 2 * N + 2;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        int           due;
    } exp_t;

    logic         clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [N-1:0] A = '0, B = '0;
    logic         busy, done, div_by_zero;
    logic [N-1:0] quotient, remainder;
    exp_t         sb[$];
    int           checks = 0, errors = 0, cyc_cnt = 0;

    restoring_divider #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        e.due = 0;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dz = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            int ia, ib;
            ia = int'($signed(a));
            ib = int'($signed(b));
            e.q = N'(ia / ib); e.r = N'(ia % ib);
`else
            e.q = a / b; e.r = a % b;
`endif
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Monitor: every done pulse pops the oldest expectation and checks it, including its arrival cycle.
    always @(negedge clk) begin
        exp_t e;
        if (reset && done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done=1 required no pending operation");
            end else begin
                e = sb.pop_front();
                checks++;
                if (cyc_cnt !== e.due) begin errors++; $display("FAIL latency: done at edge %0d required %0d", cyc_cnt, e.due); end
                checks++;
                if (quotient !== e.q) begin errors++; $display("FAIL quotient: got %0d required %0d", quotient, e.q); end
                checks++;
                if (remainder !== e.r) begin errors++; $display("FAIL remainder: got %0d required %0d", remainder, e.r); end
                checks++;
                if (div_by_zero !== e.dz) begin errors++; $display("FAIL div_by_zero: got %0b required %0b", div_by_zero, e.dz); end
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %0b required 0", busy); end
            end
        end
    end

    // Drives one start pulse and returns #1 into cycle 1 (the INIT cycle).
    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        e = model(a, b);
        @(posedge clk); #1;
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e.due = cyc_cnt + ((b == '0) ? 2 : LAT) - 1;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int t = 0;
        while (done !== 1'b1 && t < 4 * N + 8) begin @(posedge clk); #1; t++; end
    endtask

    task automatic wait_empty();
        int t = 0;
        while (sb.size() != 0 && t < 8 * N + 16) begin @(negedge clk); #1; t++; end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b required 0", done); end
        checks++; if (quotient !== '0) begin errors++; $display("FAIL reset_quotient: got %0d required 0", quotient); end
        checks++; if (remainder !== '0) begin errors++; $display("FAIL reset_remainder: got %0d required 0", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %0b required 0", div_by_zero); end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_basic();
        launch(4'd13, 4'd3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_cycle1: got %0b required 1", busy); end
        wait_done();
        launch(4'd15, 4'd1); wait_done();
        launch(4'd2, 4'd7);  wait_done();
        wait_empty();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL basic_drain: got %0d pending required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_div_by_zero();
        launch(4'd7, 4'd0); wait_done();
        launch(4'd6, 4'd2); wait_done();
        wait_empty();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL dbz_drain: got %0d pending required 0", sb.size()); sb.delete(); end
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed();
        launch(N'(-7), N'(2));  wait_done();
        launch(N'(-8), N'(-1)); wait_done();
        launch(N'(7), N'(-2));  wait_done();
        launch(N'(-8), N'(3));  wait_done();
        wait_empty();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL signed_drain: got %0d pending required 0", sb.size()); sb.delete(); end
    endtask
`endif

    task automatic test_ignored_start();
        launch(4'd13, 4'd3);
        @(posedge clk); #1;
        A = 4'd2; B = 4'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_midop: got %0b required 1", busy); end
        wait_done();
        A = 4'd15; B = 4'd15; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_in_done_idle: got busy=%0b required 0", busy); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_in_done_accepted: got busy=%0b required 0", busy); end
        wait_empty();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL ignored_drain: got %0d pending required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_back_to_back();
        exp_t prev;
        logic [N-1:0] a, b;
        for (int i = 0; i < 10; i++) begin
            a = N'($urandom_range(0, (1 << N) - 1));
            b = N'($urandom_range(0, (1 << N) - 1));
            if (i == 3) b = '0;
            launch(a, b);
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept op%0d: got busy=%0b required 1", i, busy); end
            if (i > 0) begin
                checks++; if (quotient !== prev.q) begin errors++; $display("FAIL hold_quotient op%0d: got %0d required %0d", i, quotient, prev.q); end
                checks++; if (div_by_zero !== prev.dz) begin errors++; $display("FAIL hold_dbz op%0d: got %0b required %0b", i, div_by_zero, prev.dz); end
            end
            prev = model(a, b);
            wait_done();
        end
        wait_empty();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_reset_abort();
        launch(4'd13, 4'd3);
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b0;
        void'(sb.pop_back());
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b required 0", busy); end
        checks++; if (quotient !== '0) begin errors++; $display("FAIL abort_quotient: got %0d required 0", quotient); end
        checks++; if (remainder !== '0) begin errors++; $display("FAIL abort_remainder: got %0d required 0", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL abort_dbz: got %0b required 0", div_by_zero); end
        repeat (3) begin
            @(posedge clk); #1;
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %0b required 0", done); end
        end
        reset = 1'b1;
        repeat (LAT) begin
            @(posedge clk); #1;
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_late_done: got %0b required 0", done); end
        end
        launch(4'd9, 4'd4); wait_done();
        wait_empty();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL abort_drain: got %0d pending required 0", sb.size()); sb.delete(); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_by_zero();
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        test_ignored_start();
        test_back_to_back();
        test_reset_abort();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
